// File: rtl/data_axi_lite_bridge_pkg.sv
// Shared types and constants for the data-side AXI4-Lite bridge.
package data_axi_lite_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [2:0] AXI_PROT_DATA = 3'b000;

endpackage

// File: rtl/data_axi_lite_bridge_lane_swap32.sv
// Byte-lane converter between the core's big-endian lane order and AXI little-endian lanes.
module lane_swap32 #(
  parameter bit LANE_SWAP = 1'b1
) (
  input  logic [3:0]  sel,
  input  logic [31:0] data,
  output logic [3:0]  sel_swapped,
  output logic [31:0] data_swapped
);

  generate
    if (LANE_SWAP) begin : g_swap
      for (genvar k = 0; k < 4; k++) begin : g_lane
        assign sel_swapped[k]         = sel[3-k];
        assign data_swapped[8*k +: 8] = data[8*(3-k) +: 8];
      end
    end else begin : g_pass
      assign sel_swapped  = sel;
      assign data_swapped = data;
    end
  endgenerate

endmodule

// File: rtl/data_axi_lite_bridge.sv
// MEM-stage data master: one AXI4-Lite read or write per request, stalling the pipeline until done.
module data_axi_lite_bridge
  import data_axi_lite_bridge_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter bit LANE_SWAP = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [DATA_W-1:0] mem_write_data_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] mem_read_data_o,
  output logic              stall_req_o,
  output logic              bus_err_o,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [2:0]        m_awprot,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [2:0]        m_arprot,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [3:0]        wstrb_q;
  logic              aw_pend_q, w_pend_q, drop_q;
  logic [1:0]        resp_q;
  logic              accept, r_take;

  logic [3:0]        wr_sel_sw, rd_sel_unused;
  logic [DATA_W-1:0] wr_data_sw, rd_data_sw;

  lane_swap32 #(.LANE_SWAP(LANE_SWAP)) u_wr_swap (
    .sel(mem_sel_i), .data(mem_write_data_i),
    .sel_swapped(wr_sel_sw), .data_swapped(wr_data_sw)
  );

  lane_swap32 #(.LANE_SWAP(LANE_SWAP)) u_rd_swap (
    .sel(4'b0000), .data(m_rdata),
    .sel_swapped(rd_sel_unused), .data_swapped(rd_data_sw)
  );

  assign accept = (state_q == IDLE) && mem_ce_i && !flush_i;

  // NOTE: every output and next-state term gets a default before the case, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    stall_req_o = 1'b0;
    bus_err_o   = 1'b0;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    m_bready    = 1'b0;
    r_take      = 1'b0;
    case (state_q)
      IDLE: begin
        stall_req_o = accept;
        if (accept) begin
          if (!mem_we_i)             state_d = RD_ADDR;
          else if (mem_sel_i == '0)  state_d = DONE;
          else                       state_d = WR_REQ;
        end
      end
      RD_ADDR: begin
        stall_req_o = 1'b1;
        m_arvalid   = 1'b1;
        m_rready    = 1'b1;
        if (m_arready) begin
          r_take  = m_rvalid;
          state_d = m_rvalid ? DONE : RD_DATA;
        end
      end
      RD_DATA: begin
        stall_req_o = 1'b1;
        m_rready    = 1'b1;
        if (m_rvalid) begin
          r_take  = 1'b1;
          state_d = DONE;
        end
      end
      WR_REQ: begin
        stall_req_o = 1'b1;
        m_bready    = 1'b1;
        if ((!aw_pend_q || m_awready) && (!w_pend_q || m_wready)) state_d = WR_RESP;
      end
      WR_RESP: begin
        stall_req_o = 1'b1;
        m_bready    = 1'b1;
        if (m_bvalid) state_d = DONE;
      end
      DONE: begin
        // A flushed request still completes on the bus, but its error must not reach the pipeline.
        bus_err_o = (resp_q != AXI_RESP_OKAY) && !drop_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the latched request registers are reset too, because they drive AXI outputs directly.
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      drop_q    <= 1'b0;
      resp_q    <= AXI_RESP_OKAY;
    end else begin
      state_q <= state_d;

      if (state_q == IDLE) drop_q <= 1'b0;
      else if (flush_i)    drop_q <= 1'b1;

      if (accept) begin
        addr_q    <= mem_addr_i & ~ADDR_W'(3);
        wdata_q   <= wr_data_sw;
        wstrb_q   <= wr_sel_sw;
        resp_q    <= AXI_RESP_OKAY;
        aw_pend_q <= mem_we_i && (mem_sel_i != '0);
        w_pend_q  <= mem_we_i && (mem_sel_i != '0);
      end else if (state_q == WR_REQ) begin
        if (m_awready) aw_pend_q <= 1'b0;
        if (m_wready)  w_pend_q  <= 1'b0;
      end

      if (r_take) begin
        rdata_q <= rd_data_sw;
        resp_q  <= m_rresp;
      end
      if (state_q == WR_RESP && m_bvalid) resp_q <= m_bresp;
    end
  end

  assign m_awaddr        = addr_q;
  assign m_araddr        = addr_q;
  assign m_awprot        = AXI_PROT_DATA;
  assign m_arprot        = AXI_PROT_DATA;
  assign m_awvalid       = aw_pend_q;
  assign m_wvalid        = w_pend_q;
  assign m_wdata         = wdata_q;
  assign m_wstrb         = wstrb_q;
  assign mem_read_data_o = rdata_q;

endmodule
